// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter for the shared register-file write port
// Two producers (ALU, load return) compete for one registered writeback stage.
module wb_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              mux_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_src
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_src_q, out_src_d;
  logic              last_grant_q, last_grant_d;

  logic              grant;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] mux_data;
  logic [ADDR_W-1:0] mux_addr;

  // A lone requester always wins; on a tie (or idle) the one not served last is preferred.
  always_comb begin
    grant = ~last_grant_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  assign can_accept = !out_valid_q || out_ready;
  assign req0_ready = can_accept && !grant && req0_valid && !flush && !rst;
  assign req1_ready = can_accept &&  grant && req1_valid && !flush && !rst;
  assign accept     = req0_ready || req1_ready;

  assign mux_sel  = grant;
  assign mux_data = grant ? req1_data : req0_data;
  assign mux_addr = grant ? req1_addr : req0_addr;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_addr_d   = out_addr_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = mux_data;
      out_addr_d   = mux_addr;
      out_src_d    = grant;
      last_grant_d = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // last_grant resets to 1 so that req0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_addr_q   <= out_addr_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic        clk, rst, flush, out_ready;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic [2:0]  req0_addr, req1_addr;
  logic        req0_ready, req1_ready, mux_sel, out_valid, out_src;
  logic [15:0] out_data;
  logic [2:0]  out_addr;

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .mux_sel(mux_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_src(out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        src;
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  logic m_ov = 1'b0, m_lg = 1'b1, n_ov, n_lg;
  logic exp_r0, exp_r1, exp_sel;

  // Every write the register file consumes must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got src=%0d addr=%0d data=%h, required none", out_src, out_addr, out_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (out_src !== e.src || out_addr !== e.addr || out_data !== e.data) begin
          errors++;
          $display("FAIL write_content: got src=%0d addr=%0d data=%h, required src=%0d addr=%0d data=%h",
                   out_src, out_addr, out_data, e.src, e.addr, e.data);
        end
      end
    end
  end

  task automatic sample();
    logic can, g;
    @(negedge clk);
    #1;
    can = !m_ov || out_ready;
    if (req0_valid && !req1_valid) g = 1'b0;
    else if (req1_valid && !req0_valid) g = 1'b1;
    else g = !m_lg;
    exp_sel = g;
    exp_r0 = !rst && can && !g && req0_valid && !flush;
    exp_r1 = !rst && can &&  g && req1_valid && !flush;
    n_ov = m_ov;
    n_lg = m_lg;
    if (rst) begin
      n_ov = 1'b0;
      n_lg = 1'b1;
      sb.delete();
    end else if (flush) begin
      if (m_ov && !out_ready) void'(sb.pop_front());
      n_ov = 1'b0;
    end else if (exp_r0 || exp_r1) begin
      sb.push_back('{src: g, addr: g ? req1_addr : req0_addr, data: g ? req1_data : req0_data});
      n_ov = 1'b1;
      n_lg = g;
    end else if (out_ready && m_ov) begin
      n_ov = 1'b0;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    m_ov = n_ov;
    m_lg = n_lg;
  endtask

  task automatic refresh();
    if (exp_r0) begin req0_data = 16'($urandom); req0_addr = 3'($urandom); end
    if (exp_r1) begin req1_data = 16'($urandom); req1_addr = 3'($urandom); end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h1111; req0_addr = 3'd1;
    req1_valid = 1'b1; req1_data = 16'h2222; req1_addr = 3'd2;
    for (int i = 0; i < 2; i++) begin
      sample();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got r0=%b r1=%b ov=%b, required 0 0 0", req0_ready, req1_ready, out_valid);
      end
      adv();
    end
    rst = 1'b0;
    sample();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || mux_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_tie: got r0=%b r1=%b sel=%b, required 1 0 0", req0_ready, req1_ready, mux_sel);
    end
    adv();
  endtask

  task automatic test_single();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 16'hBEEF; req1_addr = 3'd5;
    sample();
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || mux_sel !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got r0=%b r1=%b sel=%b, required 0 1 1", req0_ready, req1_ready, mux_sel);
    end
    adv();
    req1_valid = 1'b0;
    sample();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_addr !== 3'd5 || out_src !== 1'b1) begin
      errors++;
      $display("FAIL single_out: got ov=%b data=%h addr=%0d src=%b, required 1 beef 5 1", out_valid, out_data, out_addr, out_src);
    end
    adv();
  endtask

  task automatic test_contention();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 16'($urandom); req1_data = 16'($urandom);
    for (int i = 0; i < 6; i++) begin
      logic want;
      want = 1'(i % 2);
      sample();
      checks++;
      if (mux_sel !== want || req0_ready !== !want || req1_ready !== want) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got sel=%b r0=%b r1=%b, required sel=%b", i, mux_sel, req0_ready, req1_ready, want);
      end
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_src !== !want) begin
          errors++;
          $display("FAIL contention_src[%0d]: got ov=%b src=%b, required 1 %b", i, out_valid, out_src, !want);
        end
      end
      adv();
      refresh();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    sample();
    adv();
  endtask

  task automatic test_backpressure();
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    sample();
    adv();
    refresh();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_data !== sb[0].data || out_addr !== sb[0].addr || out_src !== sb[0].src) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got r0=%b r1=%b ov=%b data=%h src=%b, required 0 0 1 %h %b",
                 i, req0_ready, req1_ready, out_valid, out_data, out_src, sb[0].data, sb[0].src);
      end
      adv();
    end
    out_ready = 1'b1;
    sample();
    checks++;
    if ((req0_ready | req1_ready) !== 1'b1 || req0_ready !== exp_r0 || req1_ready !== exp_r1) begin
      errors++;
      $display("FAIL backpressure_refill: got r0=%b r1=%b, required %b %b", req0_ready, req1_ready, exp_r0, exp_r1);
    end
    adv();
    req0_valid = 1'b0; req1_valid = 1'b0;
    sample();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_refilled_valid: got %b, required 1", out_valid);
    end
    adv();
  endtask

  task automatic test_flush();
    logic [15:0] d;
    req0_valid = 1'b1; req0_data = 16'hA5A5; req0_addr = 3'd3; out_ready = 1'b1;
    sample();
    adv();
    req0_data = 16'h5A5A; req0_addr = 3'd0; d = req0_data;
    out_ready = 1'b0; flush = 1'b1;
    sample();
    checks++;
    if (req0_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: got r0=%b ov=%b, required 0 1", req0_ready, out_valid);
    end
    adv();
    flush = 1'b0;
    sample();
    checks++;
    if (out_valid !== 1'b0 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_cleared: got ov=%b r0=%b, required 0 1", out_valid, req0_ready);
    end
    adv();
    req0_valid = 1'b0; out_ready = 1'b1;
    sample();
    checks++;
    if (out_valid !== 1'b1 || out_data !== d || out_addr !== 3'd0 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: got ov=%b data=%h addr=%0d src=%b, required 1 %h 0 0", out_valid, out_data, out_addr, out_src, d);
    end
    adv();
    sample();
    adv();
  endtask

  task automatic test_reset_mid();
    req1_valid = 1'b1; req1_data = 16'h0F0F; req1_addr = 3'd6;
    sample();
    adv();
    refresh();
    req0_valid = 1'b1; req0_data = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      sample();
      adv();
      refresh();
    end
    rst = 1'b1;
    sample();
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready: got r0=%b r1=%b, required 0 0", req0_ready, req1_ready);
    end
    adv();
    rst = 1'b0;
    sample();
    checks++;
    if (out_valid !== 1'b0 || mux_sel !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_tie: got ov=%b sel=%b r0=%b r1=%b, required 0 0 1 0", out_valid, mux_sel, req0_ready, req1_ready);
    end
    adv();
    req0_valid = 1'b0; req1_valid = 1'b0;
    sample();
    adv();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_empty: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
